potato2_control: RTL
====================

# potato2_control

Parametrised second-generation Potato control unit. Each clock step it decodes one 4-bit Brainfuck-style opcode fetched by the surrounding datapath and emits a one-hot datapath command plus program-counter controls. Loop handling is new in this generation: a hardware loop stack jumps directly back to the matching `[`, and the unit falls back to bracket-counting scans when a loop is not covered by the stack. The block sits between the external program memory/PC register and the tape/accumulator/IO datapath.

## Interface
- PC_WIDTH, 8, width of program address.
- STACK_DEPTH, 8, loop-stack entries (power of two, ≥2).
- NEST_WIDTH, 16, width of scan-nesting and overflow-depth counters.
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Instruction  in  4  opcode at current PC.
- ZeroFlag  in  1  current cell == 0.
- Pc  in  PC_WIDTH  address of Instruction.
- InstrValid  in  1  Instruction/ZeroFlag/Pc valid.
- IOReady  in  1  IO transfer complete.
- Command  out  6  one-hot: 0 X_INC, 1 X_DEC, 2 A_INC, 3 A_DEC, 4 PUT, 5 GET.
- Step  out  1  one-cycle pulse; apply PC control now.
- PcInc / PcDec / PcLoad  out  1 each  mutually exclusive, valid only with Step.
- PcTarget  out  PC_WIDTH  load address, valid with PcLoad.
- Halted  out  1  halt reached.
- StackSpill  out  1  sticky: a loop was entered while the stack was full.

## Operation
- Opcodes: 0000 X_INC, 0001 X_DEC, 0010 A_INC, 0011 A_DEC, 0100 PUT, 0101 GET, 0110 `[`, 0111 `]`, 1111 HALT, all others NOP.
- FSM states: FETCH, ISSUE, IOWAIT, HALT. Mode register: RUN, SKIP_FWD, SKIP_BACK.
- FETCH: wait for InstrValid=1; sample inputs at that edge; go to ISSUE (or HALT, or IOWAIT).
- RUN mode:
  - Datapath ops and NOP: Command bit (none for NOP) and Step+PcInc in ISSUE.
  - PUT/GET: go to IOWAIT. Command bit stays high until IOReady=1 is sampled, then ISSUE with Step+PcInc and Command low.
  - `[` with ZeroFlag=1: enter SKIP_FWD with nest=0; PcInc.
  - `[` with ZeroFlag=0: if the stack is not full, push Pc; otherwise spill++ and set StackSpill. PcInc.
  - `]` with ZeroFlag=1: pop if spill==0, else spill--. PcInc.
  - `]` with ZeroFlag=0: if spill==0 and the stack is not empty, PcLoad with PcTarget = top+1 and no pop. If spill>0, enter SKIP_BACK with nest=0 and PcDec. If the stack is empty and spill==0 (unbalanced program), treat as NOP and PcInc.
  - HALT: enter HALT. Halted=1, no further Step until Reset.
- SKIP_FWD: Command stays 0 and every Step is PcInc. `[` increments nest. `]` with nest==0 returns to RUN; otherwise `]` decrements nest.
- SKIP_BACK: Command stays 0 and every Step is PcDec. `]` increments nest. `[` with nest==0 returns to RUN and issues PcInc with no push, since the loop is already counted in spill. Otherwise `[` decrements nest.
- HALT opcode inside a skip is ignored and stepped over.
- Counters (nest, spill) wrap modulo 2^NEST_WIDTH. Deeper nesting is unsupported.

## Timing
- Reset values: Command=0, Step=0, PcInc/PcDec/PcLoad=0, PcTarget=0, Halted=0, StackSpill=0. Stack empty, mode RUN, state FETCH.
- All outputs are registered.
- Latency: inputs sampled at edge E → outputs valid in the cycle after E, for exactly one cycle (except IOWAIT hold).
- Inputs are ignored outside FETCH and IOWAIT. The environment updates PC at the edge ending the Step cycle and presents the next instruction in FETCH.
- Throughput: 2 cycles per instruction minimum.
- IOReady is sampled only in IOWAIT. IOReady=1 on the first IOWAIT cycle gives 3 cycles total.
- Reset asserted mid-IOWAIT or mid-skip: immediately returns to reset values. No Step is emitted.

## Structure
- Shared package potato2_pkg holds:
  - opcode constants, Command bit indices;
  - state and mode enums;
  - Command vector width.
- Sub-module potato2_loop_stack (parameters STACK_DEPTH, PC_WIDTH): synchronous LIFO with push, pop, top, full, empty, same Clock/Reset. Simultaneous push+pop is never issued.

## Test plan
- Reset then X_INC at Pc=0 → cycle after sample: Command=000001, Step=1, PcInc=1. All other outputs 0.
- `[`@3 (Z=0), A_DEC@4, `]`@5 (Z=0) → at `]`: PcLoad=1, PcTarget=4. At `]` (Z=1): PcInc, stack empty.
- `[`@0 (Z=1), then `[`,`]`,`]` at 1..3 → three PcInc steps with Command=0. RUN resumes at Pc=4.
- STACK_DEPTH=2, three nested `[` (Z=0) → StackSpill=1. Inner `]` (Z=0) gives PcDec scan back to third `[`, then PcInc with Command=0 there.
- GET with IOReady held 0 for 5 cycles → Command[5] high for 6 cycles, then Step+PcInc.
- HALT → Halted=1, no Step for 20 cycles. Reset mid-IOWAIT of a PUT → all outputs 0 immediately.

Source files
------------

// File: rtl/potato2_pkg.sv
// potato2_pkg: shared definitions for the Potato2 control unit.
//   Opcode encodings, Command bit indices and width, FSM state and
//   loop-mode enums, and a helper that maps a datapath opcode to its
//   one-hot Command vector.
package potato2_pkg;

  localparam int CMD_W = 6;

  localparam logic [3:0] OP_X_INC = 4'b0000;
  localparam logic [3:0] OP_X_DEC = 4'b0001;
  localparam logic [3:0] OP_A_INC = 4'b0010;
  localparam logic [3:0] OP_A_DEC = 4'b0011;
  localparam logic [3:0] OP_PUT   = 4'b0100;
  localparam logic [3:0] OP_GET   = 4'b0101;
  localparam logic [3:0] OP_LOOP  = 4'b0110;
  localparam logic [3:0] OP_END   = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam int CMD_X_INC = 0;
  localparam int CMD_X_DEC = 1;
  localparam int CMD_A_INC = 2;
  localparam int CMD_A_DEC = 3;
  localparam int CMD_PUT   = 4;
  localparam int CMD_GET   = 5;

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_IOWAIT, S_HALT} state_t;
  typedef enum logic [1:0] {M_RUN, M_SKIP_FWD, M_SKIP_BACK} mode_t;

  // One-hot command for datapath/IO opcodes; zero for everything else.
  function automatic logic [CMD_W-1:0] op_cmd(input logic [3:0] op);
    logic [CMD_W-1:0] c;
    c = '0;
    case (op)
      OP_X_INC: c[CMD_X_INC] = 1'b1;
      OP_X_DEC: c[CMD_X_DEC] = 1'b1;
      OP_A_INC: c[CMD_A_INC] = 1'b1;
      OP_A_DEC: c[CMD_A_DEC] = 1'b1;
      OP_PUT:   c[CMD_PUT]   = 1'b1;
      OP_GET:   c[CMD_GET]   = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/potato2_loop_stack.sv
// potato2_loop_stack: small synchronous LIFO holding the Pc of open `[`.
//   Clock, Reset : shared clock, async active-high reset (empties stack)
//   push, din    : store din on top (ignored when full)
//   pop          : drop top entry (ignored when empty)
//   top          : current top entry (meaningless when empty)
//   full, empty  : occupancy flags
module potato2_loop_stack
  import potato2_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int PC_WIDTH    = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] din,
  output logic [PC_WIDTH-1:0] top,
  output logic                full,
  output logic                empty
);
  localparam int AW = $clog2(STACK_DEPTH);

  logic [AW:0]         cnt;
  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [AW-1:0]       top_idx;

  assign top_idx = AW'(cnt - (AW+1)'(1));
  assign top     = mem[top_idx];
  assign full    = (cnt == (AW+1)'(STACK_DEPTH));
  assign empty   = (cnt == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                cnt <= '0;
    else if (push && !full)   cnt <= cnt + (AW+1)'(1);
    else if (pop && !empty)   cnt <= cnt - (AW+1)'(1);
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge Clock) begin
    if (push && !full) mem[cnt[AW-1:0]] <= din;
  end

endmodule

// File: rtl/potato2_control.sv
// potato2_control: opcode decoder / PC sequencer for the Potato2 core.
//   Inputs : Clock, Reset (async, active high), Instruction, ZeroFlag, Pc,
//            InstrValid (qualifies the three before), IOReady.
//   Outputs: Command (one-hot datapath op), Step pulse with exactly one of
//            PcInc/PcDec/PcLoad, PcTarget (with PcLoad), Halted, StackSpill.
//   Loops whose `[` fit in the stack jump straight back; loops entered while
//   the stack was full are tracked only by the spill count and found again by
//   a backward bracket scan.
module potato2_control
  import potato2_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 8,
  parameter int NEST_WIDTH  = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [3:0]          Instruction,
  input  logic                ZeroFlag,
  input  logic [PC_WIDTH-1:0] Pc,
  input  logic                InstrValid,
  input  logic                IOReady,
  output logic [CMD_W-1:0]    Command,
  output logic                Step,
  output logic                PcInc,
  output logic                PcDec,
  output logic                PcLoad,
  output logic [PC_WIDTH-1:0] PcTarget,
  output logic                Halted,
  output logic                StackSpill
);
  state_t state, state_n;
  mode_t  mode, mode_n;
  logic [NEST_WIDTH-1:0] nest, nest_n, spill, spill_n;
  logic [CMD_W-1:0]      cmd_n;
  logic [PC_WIDTH-1:0]   tgt_n, stk_top;
  logic step_n, inc_n, dec_n, load_n, halted_n, spill_flag_n;
  logic push, pop, stk_full, stk_empty;

  potato2_loop_stack #(.STACK_DEPTH(STACK_DEPTH), .PC_WIDTH(PC_WIDTH)) u_stack (
    .Clock(Clock), .Reset(Reset), .push(push), .pop(pop), .din(Pc),
    .top(stk_top), .full(stk_full), .empty(stk_empty)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_FETCH;  mode <= M_RUN;
      nest <= '0;        spill <= '0;
      Command <= '0;     Step <= 1'b0;
      PcInc <= 1'b0;     PcDec <= 1'b0;  PcLoad <= 1'b0;
      PcTarget <= '0;    Halted <= 1'b0; StackSpill <= 1'b0;
    end else begin
      state <= state_n;  mode <= mode_n;
      nest <= nest_n;    spill <= spill_n;
      Command <= cmd_n;  Step <= step_n;
      PcInc <= inc_n;    PcDec <= dec_n; PcLoad <= load_n;
      PcTarget <= tgt_n; Halted <= halted_n; StackSpill <= spill_flag_n;
    end
  end

  always_comb begin
    state_n = state;  mode_n = mode;
    nest_n = nest;    spill_n = spill;
    cmd_n = '0;       step_n = 1'b0;
    inc_n = 1'b0;     dec_n = 1'b0;  load_n = 1'b0;
    tgt_n = '0;       halted_n = Halted;  spill_flag_n = StackSpill;
    push = 1'b0;      pop = 1'b0;

    case (state)
      S_FETCH: if (InstrValid) begin
        state_n = S_ISSUE;
        step_n  = 1'b1;
        case (mode)
          M_RUN: case (Instruction)
            OP_X_INC, OP_X_DEC, OP_A_INC, OP_A_DEC: begin
              cmd_n = op_cmd(Instruction);
              inc_n = 1'b1;
            end
            OP_PUT, OP_GET: begin
              // Command is held through IOWAIT; the Step comes afterwards.
              state_n = S_IOWAIT;
              step_n  = 1'b0;
              cmd_n   = op_cmd(Instruction);
            end
            OP_LOOP: begin
              inc_n = 1'b1;
              if (ZeroFlag) begin
                mode_n = M_SKIP_FWD;
                nest_n = '0;
              end else if (!stk_full) begin
                push = 1'b1;
              end else begin
                spill_n      = spill + NEST_WIDTH'(1);
                spill_flag_n = 1'b1;
              end
            end
            OP_END: begin
              if (ZeroFlag) begin
                inc_n = 1'b1;
                if (spill == '0) pop = !stk_empty;
                else             spill_n = spill - NEST_WIDTH'(1);
              end else if (spill != '0) begin
                // Innermost open loop is not on the stack: scan back for it.
                mode_n = M_SKIP_BACK;
                nest_n = '0;
                dec_n  = 1'b1;
              end else if (!stk_empty) begin
                load_n = 1'b1;
                tgt_n  = stk_top + PC_WIDTH'(1);
              end else begin
                inc_n = 1'b1;  // unmatched `]`
              end
            end
            OP_HALT: begin
              state_n  = S_HALT;
              step_n   = 1'b0;
              halted_n = 1'b1;
            end
            default: inc_n = 1'b1;
          endcase
          M_SKIP_FWD: begin
            inc_n = 1'b1;
            if (Instruction == OP_LOOP) nest_n = nest + NEST_WIDTH'(1);
            else if (Instruction == OP_END) begin
              if (nest == '0) mode_n = M_RUN;
              else            nest_n = nest - NEST_WIDTH'(1);
            end
          end
          M_SKIP_BACK: begin
            dec_n = 1'b1;
            if (Instruction == OP_END) nest_n = nest + NEST_WIDTH'(1);
            else if (Instruction == OP_LOOP) begin
              if (nest == '0) begin
                // Loop re-entered; it is still accounted for in spill.
                mode_n = M_RUN;
                dec_n  = 1'b0;
                inc_n  = 1'b1;
              end else begin
                nest_n = nest - NEST_WIDTH'(1);
              end
            end
          end
          default: mode_n = M_RUN;
        endcase
      end
      S_ISSUE: state_n = S_FETCH;
      S_IOWAIT: begin
        cmd_n = Command;
        if (IOReady) begin
          cmd_n   = '0;
          step_n  = 1'b1;
          inc_n   = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_HALT: halted_n = 1'b1;
      default: state_n = S_FETCH;
    endcase
  end

endmodule
